// File: rtl/block_assembler.sv
// Packs WORD_W-bit bus words into one WORDS-word block tagged as key or data.
// Optional BYTE_SWAP_EN byte-reverses each accepted word before it is stored.
module block_assembler #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W-1:0]         word_in,
  input  logic                      word_valid,
  input  logic                      word_type,
  output logic                      word_ready,
  input  logic                      flush,
  output logic [WORD_W*WORDS-1:0]   block_out,
  output logic                      block_type,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic [2:0]                word_count,
  output logic                      type_err
);

  localparam int unsigned BLOCK_W = WORD_W * WORDS;

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e             state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic               type_q, type_d;
  logic               err_q, err_d;
  logic [BLOCK_W-1:0] block_q, block_d;

  logic               accept;
  logic               wr_en;
  logic [2:0]         wr_idx;
  logic [WORD_W-1:0]  word_s;

`ifdef BYTE_SWAP_EN
  always_comb begin
    word_s = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++) begin
      word_s[b*8 +: 8] = word_in[WORD_W-8-b*8 +: 8];
    end
  end
`else
  assign word_s = word_in;
`endif

  assign accept = word_valid & word_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      type_q  <= 1'b0;
      err_q   <= 1'b0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      type_q  <= type_d;
      err_q   <= err_d;
      block_q <= block_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    type_d  = type_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    if (flush) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wr_en   = 1'b1;
            type_d  = word_type;
            count_d = 3'd1;
            state_d = StFill;
          end
        end
        StFill: begin
          if (accept) begin
            wr_en = 1'b1;
            if (word_type == type_q) begin
              wr_idx  = count_q;
              count_d = count_q + 3'd1;
              if (count_q == 3'(WORDS - 1)) state_d = StFull;
            end else begin
              // Abandon the partial block; the new word starts a fresh one.
              err_d   = 1'b1;
              type_d  = word_type;
              count_d = 3'd1;
            end
          end
        end
        StFull: begin
          if (block_ready) begin
            if (accept) begin
              wr_en   = 1'b1;
              type_d  = word_type;
              count_d = 3'd1;
              state_d = StFill;
            end else begin
              count_d = '0;
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  // Word k lands MSW-first
  always_comb begin
    block_d = block_q;
    if (wr_en) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (wr_idx == 3'(k)) block_d[BLOCK_W-1-k*WORD_W -: WORD_W] = word_s;
      end
    end
  end

  // Outputs
  always_comb begin
    word_ready  = 1'b0;
    if (!flush) word_ready = (state_q == StFull) ? block_ready : 1'b1;
    block_valid = (state_q == StFull);
    block_out   = block_q;
    block_type  = type_q;
    word_count  = count_q;
    type_err    = err_q;
  end

endmodule
